fetch_controller: RTL

FETCH_CONTROLLER -- requirements
Module: fetch_controller

---
 rtl/fetch_controller_if.sv | 36 +++
 rtl/fetch_controller.sv | 101 ++++++++++
 2 files changed

// File: rtl/fetch_controller_if.sv
// Fetch-side bundle: redirect request, instruction-memory request/response and decode output.
interface fetch_controller_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  redirect_i;
    logic                  redirect_abs_i;
    logic [ADDR_WIDTH-1:0] redirect_offset_i;

    logic                  imem_req_o;
    logic [ADDR_WIDTH-1:0] imem_addr_o;
    logic                  imem_gnt_i;
    logic                  imem_rvalid_i;
    logic [31:0]           imem_rdata_i;

    logic                  instr_valid_o;
    logic [31:0]           instr_o;
    logic [ADDR_WIDTH-1:0] instr_pc_o;
    logic                  instr_ready_i;

    // master = fetch controller, slave = memory/decode/branch environment
    modport master (
        input  redirect_i, redirect_abs_i, redirect_offset_i,
        output imem_req_o, imem_addr_o,
        input  imem_gnt_i, imem_rvalid_i, imem_rdata_i,
        output instr_valid_o, instr_o, instr_pc_o,
        input  instr_ready_i
    );

    modport slave (
        output redirect_i, redirect_abs_i, redirect_offset_i,
        input  imem_req_o, imem_addr_o,
        output imem_gnt_i, imem_rvalid_i, imem_rdata_i,
        input  instr_valid_o, instr_o, instr_pc_o,
        output instr_ready_i
    );
endinterface

// File: rtl/fetch_controller.sv
// Single-outstanding instruction fetcher (REQ -> WAIT -> OUT): 3 cycles per instruction at best.
// Stalls in OUT until decode accepts; redirects squash the in-flight response via a kill flag.
module fetch_controller #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = {ADDR_WIDTH{1'b0}}
) (
    input  logic               clk,
    input  logic               rst_n,
    fetch_controller_if.master bus
);

    typedef enum logic [1:0] {
        ST_REQ,
        ST_WAIT,
        ST_OUT
    } state_t;

    state_t                state;
    logic                  kill;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] tgt_sum;
    logic [ADDR_WIDTH-1:0] target;

    // Relative targets are taken from the last presented instruction's PC.
    always_comb begin
        tgt_sum = bus.redirect_abs_i ? bus.redirect_offset_i
                                     : bus.instr_pc_o + bus.redirect_offset_i;
        target  = {tgt_sum[ADDR_WIDTH-1:2], 2'b00};
    end

    assign bus.imem_addr_o = pc;

    // imem_req_o is registered so it stays low through reset and rises on the first edge after.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= ST_REQ;
            kill              <= 1'b0;
            pc                <= RESET_ADDR;
            bus.imem_req_o    <= 1'b0;
            bus.instr_valid_o <= 1'b0;
            bus.instr_o       <= '0;
            bus.instr_pc_o    <= '0;
        end else begin
            unique case (state)
                ST_REQ: begin
                    bus.imem_req_o <= 1'b1;
                    if (bus.redirect_i) begin
                        pc <= target;
                    end
                    if (bus.imem_req_o && bus.imem_gnt_i) begin
                        state          <= ST_WAIT;
                        kill           <= bus.redirect_i;
                        bus.imem_req_o <= 1'b0;
                    end
                end

                ST_WAIT: begin
                    if (bus.redirect_i) begin
                        pc <= target;
                    end
                    if (bus.imem_rvalid_i) begin
                        if (kill || bus.redirect_i) begin
                            kill           <= 1'b0;
                            state          <= ST_REQ;
                            bus.imem_req_o <= 1'b1;
                        end else begin
                            bus.instr_o       <= bus.imem_rdata_i;
                            bus.instr_pc_o    <= pc;
                            bus.instr_valid_o <= 1'b1;
                            state             <= ST_OUT;
                        end
                    end else if (bus.redirect_i) begin
                        kill <= 1'b1;
                    end
                end

                ST_OUT: begin
                    // Redirect wins over a simultaneous accept; PC is not advanced.
                    if (bus.redirect_i) begin
                        pc                <= target;
                        bus.instr_valid_o <= 1'b0;
                        bus.imem_req_o    <= 1'b1;
                        state             <= ST_REQ;
                    end else if (bus.instr_ready_i) begin
                        pc                <= pc + ADDR_WIDTH'(4);
                        bus.instr_valid_o <= 1'b0;
                        bus.imem_req_o    <= 1'b1;
                        state             <= ST_REQ;
                    end
                end

                default: begin
                    state          <= ST_REQ;
                    kill           <= 1'b0;
                    bus.imem_req_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
